ace_fetch_pcctl: RTL

Fetch PC sequencer and redirect arbiter for the ace21064 two-stage fetch pipeline. It owns the registered f0 and f1 PCs and their valid bits. It arbitrates between four next-PC sources: retire flush, f1 override, f0 prediction and hold. It issues the icache fetch request and stalls the pipeline on icache or back-pressure. It also keeps saturating redirect counters for performance analysis.

---
 rtl/ace_fetch_pkg.sv | 24 ++
 rtl/ace_fetch_pcctl_if.sv | 25 ++
 rtl/ace_satcnt.sv | 37 +++
 rtl/ace_fetch_pcctl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ace_fetch_pkg.sv
// Shared fetch types and constants for the ace21064 fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ace_fetch_pkg;

    // Fetch-PC sequencer FSM encoding; values are visible on the debug state port.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } pcctl_state_e;

    localparam int unsigned FETCH_BLK_BYTES = 32;

    // Clears the byte offset within a fetch block to form the icache line address.
    localparam logic [63:0] LINE_MASK = ~(64'(FETCH_BLK_BYTES) - 64'd1);

    // Every PC loaded into the pipeline is instruction-aligned.
    function automatic logic [63:0] pc_align(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ace_fetch_pcctl_if.sv
// Icache request channel between the fetch PC sequencer and the icache.
// Latency: n/a (wires only).
// Backpressure: icache_rdy_i / icache_stall_i from the icache hold the request.
interface ace_fetch_pcctl_if;
    logic        icache_req_o;
    logic [63:0] icache_addr_o;
    logic        icache_rdy_i;
    logic        icache_stall_i;

    // Fetch sequencer side: drives the request, sees icache readiness.
    modport master (
        output icache_req_o,
        output icache_addr_o,
        input  icache_rdy_i,
        input  icache_stall_i
    );

    // Icache side.
    modport slave (
        input  icache_req_o,
        input  icache_addr_o,
        output icache_rdy_i,
        output icache_stall_i
    );
endinterface

// File: rtl/ace_satcnt.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones.
// Latency: count visible the cycle after the increment.
// Backpressure: none; increments at saturation are dropped.
module ace_satcnt
    import ace_fetch_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ace_fetch_pcctl.sv
// Fetch PC sequencer: owns f0/f1 PCs, arbitrates flush > override > advance > hold.
// Latency: redirect visible on pc_f0_o next cycle; flush reaches the icache two cycles later.
// Backpressure: icache not ready/stalled, instbuf full or BOB full freeze f0 (HOLD).
module ace_fetch_pcctl
    import ace_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_rt_i,
    input  logic [63:0]       flush_pc_rt_i,
    input  logic              override_vld_f1_i,
    input  logic [63:0]       override_pc_f1_i,
    input  logic [63:0]       nxt_pc_f0_i,
    input  logic              instbuf_full_i,
    input  logic              bob_stall_i,
    ace_fetch_pcctl_if.master ic,
    output logic [63:0]       pc_f0_o,
    output logic [63:0]       pc_f1_o,
    output logic              f0_vld_o,
    output logic              f1_vld_o,
    output logic              kill_f1_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  ovr_cnt_o
);

    pcctl_state_e state_d, state_q;
    logic [63:0]  pc_f0_d, pc_f0_q;
    logic [63:0]  pc_f1_d, pc_f1_q;
    logic         f0_vld_d, f0_vld_q;
    logic         f1_vld_d, f1_vld_q;

    logic         icache_req;
    logic         downstream_ok;
    logic         would_advance;
    logic         advance;
    logic         ovr_take;
    logic         flush_inc;
    logic         ovr_inc;

    // Request only while running with a live f0; the rest gates whether it is consumed.
    always_comb begin
        icache_req    = f0_vld_q && (state_q == ST_RUN);
        downstream_ok = !instbuf_full_i && !bob_stall_i;
        would_advance = f0_vld_q && ic.icache_rdy_i && !ic.icache_stall_i && downstream_ok;
        advance       = icache_req && would_advance;
        ovr_take      = override_vld_f1_i && f1_vld_q;
        flush_inc     = flush_rt_i;
        ovr_inc       = !flush_rt_i && ovr_take;
    end

    // Next-PC arbitration and FSM transitions.
    always_comb begin
        state_d  = state_q;
        pc_f0_d  = pc_f0_q;
        pc_f1_d  = pc_f1_q;
        f0_vld_d = f0_vld_q;
        f1_vld_d = f1_vld_q;

        if (flush_rt_i) begin
            // Retire flush beats everything, including an in-progress FLUSH bubble.
            state_d  = ST_FLUSH;
            pc_f0_d  = pc_align(flush_pc_rt_i);
            f0_vld_d = 1'b0;
            f1_vld_d = 1'b0;
        end else if (state_q == ST_BOOT) begin
            state_d  = ST_RUN;
            pc_f0_d  = pc_align(RESET_PC);
            f0_vld_d = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // One-cycle bubble done; restart fetch at the flush target already in f0.
            state_d  = ST_RUN;
            f0_vld_d = 1'b1;
        end else if (ovr_take) begin
            // Override wins over HOLD too; f1 content is kept by the fetch unit up to the branch.
            state_d  = ST_RUN;
            pc_f0_d  = pc_align(override_pc_f1_i);
            f0_vld_d = 1'b1;
            f1_vld_d = 1'b0;
        end else if (advance) begin
            state_d  = ST_RUN;
            pc_f1_d  = pc_f0_q;
            f1_vld_d = 1'b1;
            pc_f0_d  = pc_align(nxt_pc_f0_i);
        end else begin
            // Stalled: PCs hold; f1 drains if the instruction buffer took it.
            if (downstream_ok) begin
                f1_vld_d = 1'b0;
            end
            if (state_q == ST_RUN && f0_vld_q) begin
                state_d = ST_HOLD;
            end else if (state_q == ST_HOLD && would_advance) begin
                state_d = ST_RUN;
            end
        end
    end

    // Pipeline PC/valid/state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BOOT;
            pc_f0_q  <= RESET_PC;
            pc_f1_q  <= '0;
            f0_vld_q <= 1'b0;
            f1_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_f0_q  <= pc_f0_d;
            pc_f1_q  <= pc_f1_d;
            f0_vld_q <= f0_vld_d;
            f1_vld_q <= f1_vld_d;
        end
    end

    ace_satcnt #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (flush_inc),
        .cnt_o   (flush_cnt_o)
    );

    ace_satcnt #(.W(CNT_W)) u_ovr_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (ovr_inc),
        .cnt_o   (ovr_cnt_o)
    );

    assign ic.icache_req_o  = icache_req;
    assign ic.icache_addr_o = pc_f0_q & LINE_MASK;
    assign pc_f0_o          = pc_f0_q;
    assign pc_f1_o          = pc_f1_q;
    assign f0_vld_o         = f0_vld_q;
    assign f1_vld_o         = f1_vld_q;
    assign kill_f1_o        = flush_rt_i || (state_q == ST_FLUSH);
    assign state_o          = state_q;

endmodule
